// File: rtl/branch_resolve_buffer_if.sv
// rtl/branch_resolve_buffer_if.sv - dispatch, CDB and predictor-update signal bundle for branch_resolve_buffer
//
// Purpose: groups every non-clock/reset signal of branch_resolve_buffer.
//   master modport : the environment (dispatch, CDB, predictor, stats reader)
//   slave modport  : the branch_resolve_buffer itself
// Signal summary:
//   Dis_BrAlloc/Dis_BrPCBits/Dis_BrPrediction        dispatch allocation request
//   Brb_AllocTag/Brb_Full                            allocation tag and back-pressure
//   Cdb_Valid/Cdb_Branch/Cdb_BrTag/Cdb_BranchOutcome CDB branch resolution
//   Brb_Mispredict/Brb_MispredictTag                 registered mispredict pulse
//   Dis_CdbUpdBranch/Dis_CdbUpdBranchAddr/
//   Dis_CdbBranchOutcome                             registered predictor update
//   Brb_RetireCnt/Brb_MispCnt                        statistics (zero unless BRB_STATS_EN)
interface branch_resolve_buffer_if #(
  parameter int TAG_W = 2,
  parameter int PCB_W = 3
);
  logic             Dis_BrAlloc;
  logic [PCB_W-1:0] Dis_BrPCBits;
  logic             Dis_BrPrediction;
  logic [TAG_W-1:0] Brb_AllocTag;
  logic             Brb_Full;

  logic             Cdb_Valid;
  logic             Cdb_Branch;
  logic [TAG_W-1:0] Cdb_BrTag;
  logic             Cdb_BranchOutcome;

  logic             Brb_Mispredict;
  logic [TAG_W-1:0] Brb_MispredictTag;

  logic             Dis_CdbUpdBranch;
  logic [PCB_W-1:0] Dis_CdbUpdBranchAddr;
  logic             Dis_CdbBranchOutcome;

  logic [15:0]      Brb_RetireCnt;
  logic [15:0]      Brb_MispCnt;

  modport master (
    output Dis_BrAlloc, Dis_BrPCBits, Dis_BrPrediction,
    output Cdb_Valid, Cdb_Branch, Cdb_BrTag, Cdb_BranchOutcome,
    input  Brb_AllocTag, Brb_Full,
    input  Brb_Mispredict, Brb_MispredictTag,
    input  Dis_CdbUpdBranch, Dis_CdbUpdBranchAddr, Dis_CdbBranchOutcome,
    input  Brb_RetireCnt, Brb_MispCnt
  );

  modport slave (
    input  Dis_BrAlloc, Dis_BrPCBits, Dis_BrPrediction,
    input  Cdb_Valid, Cdb_Branch, Cdb_BrTag, Cdb_BranchOutcome,
    output Brb_AllocTag, Brb_Full,
    output Brb_Mispredict, Brb_MispredictTag,
    output Dis_CdbUpdBranch, Dis_CdbUpdBranchAddr, Dis_CdbBranchOutcome,
    output Brb_RetireCnt, Brb_MispCnt
  );
endinterface

// File: rtl/branch_resolve_buffer.sv
// rtl/branch_resolve_buffer.sv - in-order retire buffer for conditional branches resolved out of order on the CDB
//
// Purpose: dispatch allocates one entry per conditional branch (index = branch tag),
//   the CDB resolves entries in any order, a wrong prediction raises a one-cycle
//   mispredict pulse and flushes every younger entry, and resolved entries retire
//   in program order one per cycle as a registered predictor-update triple.
// Ports:
//   clk     rising-edge clock
//   resetb  asynchronous active-low reset (all entries invalid, all outputs 0)
//   brb     slave modport of branch_resolve_buffer_if (dispatch, CDB, update, stats)
// Configuration:
//   BRB_STATS_EN  when defined, builds saturating 16-bit retire and mispredict
//                 counters; otherwise Brb_RetireCnt/Brb_MispCnt are tied to 0.
module branch_resolve_buffer #(
  parameter int TAG_W = 2,
  parameter int PCB_W = 3
) (
  input logic                    clk,
  input logic                    resetb,
  branch_resolve_buffer_if.slave brb
);
  localparam int DEPTH = 2 ** TAG_W;
  localparam int CNT_W = TAG_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // Entry storage
  logic             entValid    [DEPTH];
  logic [PCB_W-1:0] entPcBits   [DEPTH];
  logic             entPred     [DEPTH];
  logic             entResolved [DEPTH];
  logic             entOutcome  [DEPTH];

  tag_t head;
  tag_t tail;
  cnt_t count;
  tag_t headNext;
  tag_t tailNext;
  cnt_t countNext;

  tag_t cdbTag;
  tag_t tagAge;
  logic resolveHit;
  logic mispDetect;
  logic allocDo;
  logic retireDo;
  logic flushEnt [DEPTH];

  // Registered outputs
  logic             mispReg;
  tag_t             mispTagReg;
  logic             updReg;
  logic [PCB_W-1:0] updAddrReg;
  logic             updOutcomeReg;

  assign cdbTag = brb.Cdb_BrTag;

  // Only a still-pending valid entry can be resolved; repeats and stale tags are ignored.
  assign resolveHit = brb.Cdb_Valid && brb.Cdb_Branch &&
                      entValid[cdbTag] && !entResolved[cdbTag];
  assign mispDetect = resolveHit && (brb.Cdb_BranchOutcome != entPred[cdbTag]);

  // An allocation in a mispredict cycle would land on the wrong path, so drop it.
  assign allocDo  = brb.Dis_BrAlloc && !brb.Brb_Full && !mispDetect;

  // Retire looks at stored state only, so a same-cycle CDB result waits one cycle.
  assign retireDo = entValid[head] && entResolved[head];

  // Age of the resolving branch relative to the oldest entry (wraps mod DEPTH).
  assign tagAge = cdbTag - head;

  assign brb.Brb_AllocTag = tail;
  assign brb.Brb_Full     = (count == FULL_COUNT);

  // Valid entries are contiguous from head, so "younger than the mispredicted
  // branch" is simply a larger age measured from head.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      flushEnt[i] = mispDetect && entValid[i] && ((tag_t'(i) - head) > tagAge);
    end
  end

  always_comb begin
    headNext = head + tag_t'(retireDo);
    if (mispDetect) begin
      tailNext  = cdbTag + tag_t'(1);
      countNext = {1'b0, tagAge} + cnt_t'(1) - cnt_t'(retireDo);
    end else begin
      tailNext  = tail + tag_t'(allocDo);
      countNext = count + cnt_t'(allocDo) - cnt_t'(retireDo);
    end
  end

  // Pointer and entry state. Flush, resolve, retire and allocate never touch the
  // same entry in one cycle: flushed entries are younger than the resolving one,
  // the retiring head is already resolved, and the tail slot is always invalid
  // when an allocation is accepted.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entValid[i]    <= 1'b0;
        entPcBits[i]   <= '0;
        entPred[i]     <= 1'b0;
        entResolved[i] <= 1'b0;
        entOutcome[i]  <= 1'b0;
      end
    end else begin
      head  <= headNext;
      tail  <= tailNext;
      count <= countNext;
      for (int i = 0; i < DEPTH; i++) begin
        if (flushEnt[i]) begin
          entValid[i]    <= 1'b0;
          entResolved[i] <= 1'b0;
        end
      end
      if (resolveHit) begin
        entResolved[cdbTag] <= 1'b1;
        entOutcome[cdbTag]  <= brb.Cdb_BranchOutcome;
      end
      if (retireDo) begin
        entValid[head]    <= 1'b0;
        entResolved[head] <= 1'b0;
      end
      if (allocDo) begin
        entValid[tail]    <= 1'b1;
        entResolved[tail] <= 1'b0;
        entPcBits[tail]   <= brb.Dis_BrPCBits;
        entPred[tail]     <= brb.Dis_BrPrediction;
      end
    end
  end

  // Mispredict pulse and predictor update; address/outcome hold between updates.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      mispReg       <= 1'b0;
      mispTagReg    <= '0;
      updReg        <= 1'b0;
      updAddrReg    <= '0;
      updOutcomeReg <= 1'b0;
    end else begin
      mispReg <= mispDetect;
      if (mispDetect) begin
        mispTagReg <= cdbTag;
      end
      updReg <= retireDo;
      if (retireDo) begin
        updAddrReg    <= entPcBits[head];
        updOutcomeReg <= entOutcome[head];
      end
    end
  end

  assign brb.Brb_Mispredict       = mispReg;
  assign brb.Brb_MispredictTag    = mispTagReg;
  assign brb.Dis_CdbUpdBranch     = updReg;
  assign brb.Dis_CdbUpdBranchAddr = updAddrReg;
  assign brb.Dis_CdbBranchOutcome = updOutcomeReg;

`ifdef BRB_STATS_EN
  logic [15:0] retireCnt;
  logic [15:0] mispCnt;

  // Counters advance on the same edge that raises the update / mispredict pulse.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      retireCnt <= '0;
      mispCnt   <= '0;
    end else begin
      if (retireDo && (retireCnt != 16'hFFFF)) begin
        retireCnt <= retireCnt + 16'd1;
      end
      if (mispDetect && (mispCnt != 16'hFFFF)) begin
        mispCnt <= mispCnt + 16'd1;
      end
    end
  end

  assign brb.Brb_RetireCnt = retireCnt;
  assign brb.Brb_MispCnt   = mispCnt;
`else
  assign brb.Brb_RetireCnt = '0;
  assign brb.Brb_MispCnt   = '0;
`endif

endmodule

// File: doc/branch_resolve_buffer.md
Name: branch_resolve_buffer

Overview:
- Sits between dispatch, the CDB and the branch prediction buffer.
- Dispatch allocates one entry per dispatched conditional branch, storing PC[4:2] and the predicted direction; the entry's index is the branch tag.
- CDB resolution marks an entry resolved out of order; a mispredict is flagged immediately and all younger entries are flushed.
- Resolved entries retire in program order, one per cycle, producing the registered update triple consumed by the prediction buffer.

Parameters:
- TAG_W, 2, tag width; DEPTH = 2**TAG_W entries.
- PCB_W, 3, PC index bits stored per entry (PC[4:2]).

Ports:
- clk  in  1  clock, rising edge
- resetb  in  1  asynchronous active-low reset
- Dis_BrAlloc  in  1  dispatch allocates a branch entry this cycle
- Dis_BrPCBits  in  PCB_W  PC[4:2] of the allocating branch
- Dis_BrPrediction  in  1  predicted direction (1 = taken)
- Brb_AllocTag  out  TAG_W  tag assigned to an allocation this cycle (= tail pointer, combinational)
- Brb_Full  out  1  all DEPTH entries valid (combinational from count)
- Cdb_Valid  in  1  CDB broadcast valid
- Cdb_Branch  in  1  broadcast is a branch resolution
- Cdb_BrTag  in  TAG_W  tag of the resolving branch
- Cdb_BranchOutcome  in  1  actual direction (1 = taken)
- Brb_Mispredict  out  1  registered one-cycle pulse: a branch resolved opposite to its prediction
- Brb_MispredictTag  out  TAG_W  tag of the mispredicted branch
- Dis_CdbUpdBranch  out  1  registered predictor update valid
- Dis_CdbUpdBranchAddr  out  PCB_W  predictor index to update
- Dis_CdbBranchOutcome  out  1  outcome to train with
- Brb_RetireCnt  out  16  retired-branch count (optional feature)
- Brb_MispCnt  out  16  mispredict count (optional feature)

Behaviour:
- Entry state: valid, pcbits, pred, resolved, outcome. Pointers head and tail are TAG_W bits and wrap mod DEPTH. count is TAG_W+1 bits.
- Reset (asynchronous, any time, including mid-operation): all entries invalid; head = tail = count = 0; every output is 0.
- Allocate:
  - Condition: Dis_BrAlloc && !Brb_Full && no mispredict detected this cycle.
  - Action: write entry[tail] with valid=1, resolved=0; tail++.
  - Allocation while full, or in a cycle where a mispredict is detected, is dropped silently. Dispatch must stall.
- Resolve:
  - Condition: Cdb_Valid && Cdb_Branch && entry[Cdb_BrTag].valid && !resolved.
  - Action: set resolved and outcome.
  - Resolution of an invalid or already-resolved entry is ignored.
- Mispredict:
  - Detected when a resolve has outcome != pred.
  - Next cycle: Brb_Mispredict = 1 and Brb_MispredictTag = tag, for one cycle.
  - Flush: entries strictly younger than the tag (tag+1 .. tail-1, mod DEPTH) are invalidated; tail <= tag+1; count <= ((tag - head) mod DEPTH) + 1, minus 1 if head also retires this cycle.
- Retire:
  - Condition: entry[head].valid && entry[head].resolved, using stored state only.
  - Action: next cycle Dis_CdbUpdBranch = 1, Dis_CdbUpdBranchAddr = pcbits, Dis_CdbBranchOutcome = outcome. Entry cleared; head++.
  - Otherwise Dis_CdbUpdBranch = 0. Addr and outcome hold their last values.
- Latency:
  - CDB to mispredict pulse: 1 cycle.
  - CDB to predictor update: minimum 2 cycles, because a resolved bit set in cycle N is first visible to retire in N+1.
- Simultaneous events:
  - Allocate and retire in the same cycle: both occur; count unchanged.
  - Retire and mispredict flush in the same cycle: both apply.
  - Allocate and resolve of different tags in the same cycle: both apply.
- Brb_Full = (count == DEPTH).

Optional Feature:
- BRB_STATS_EN defined:
  - Brb_RetireCnt increments on every retire.
  - Brb_MispCnt increments on every mispredict pulse.
  - Both are 16-bit, saturate at 16'hFFFF and reset to 0.
- Not defined: both ports are tied to 0 and no counter logic is built.

Test Plan:
- Reset, allocate PC bits 3'b101 with pred=1 (tag 0), CDB resolve tag 0 taken -> Brb_Mispredict stays 0; two cycles after the CDB, Dis_CdbUpdBranch=1 with Addr=3'b101, Outcome=1 for one cycle.
- Allocate 4 branches -> Brb_Full=1 and tags 0,1,2,3; a 5th Dis_BrAlloc is dropped and count stays 4.
- Resolve tag 2 then tag 1 before tag 0, then resolve tag 0 -> updates emerge in order: tag 0, then 1, then 2, on consecutive cycles.
- 4 entries valid, resolve tag 1 with pred=0 and outcome=1 -> next cycle Brb_Mispredict=1, Tag=1; entries 2 and 3 invalid; tail=2; count=2; Brb_Full=0.
- Assert resetb low while entries are resolved and pending -> outputs immediately 0, Brb_AllocTag=0, no update pulse after release.
- With BRB_STATS_EN, 3 retires including 1 mispredict -> Brb_RetireCnt=3, Brb_MispCnt=1.
